spi_dac_rx: RTL and testbench

//  SPI slave that receives the 32-bit DAC command frames our DAC driver transmits.

---
 rtl/dac_defs.sv | 40 ++++
 rtl/sync_edge.sv | 35 +++
 rtl/spi_dac_rx.sv | 199 +++++++++++++++++++
 tb/tb_spi_dac_rx.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_defs.sv
// Shared constants for the SPI DAC command frame. The DAC driver builds its
// frames from this same package, so both ends agree on field positions.
package dac_defs;

  localparam int FRAME_BITS = 32;
  localparam int DATA_W     = 12;
  localparam int NUM_CH     = 2;

  localparam logic [3:0] ADDR_ALL = 4'b1111;

  // Command codes
  localparam logic [3:0] CMD_WR_IN      = 4'b0000;
  localparam logic [3:0] CMD_UPD        = 4'b0001;
  localparam logic [3:0] CMD_WR_UPD_ALL = 4'b0010;
  localparam logic [3:0] CMD_WR_UPD     = 4'b0011;
  localparam logic [3:0] CMD_PWR_DN     = 4'b0100;

  // Field positions inside the 32-bit frame (bit 31 is sent first)
  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 4;

  // Bit counter saturates one past a full frame so overruns stay visible
  localparam int              CNT_W   = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_BITS + 1);

  // Clocks after reset release during which synchronizer edges are ignored,
  // long enough for the sync pipeline to fill with real pin levels.
  localparam logic [2:0] SETTLE_CYC = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus registered
// single-cycle rise/fall pulses derived from the synchronized level.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Sync chain, edge-history flop and edge pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s3   <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  assign q = s2;

endmodule

// File: rtl/spi_dac_rx.sv
// SPI slave receiving 32-bit DAC command frames. Holds the FSM, shift
// register, bit counter and per-channel input/output/power-down registers.
// dbg_state exposes the FSM state for debug and assertion binding.
module spi_dac_rx
  import dac_defs::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_sck,
  input  logic                     spi_mosi,
  input  logic                     dac_cs,
  input  logic                     dac_clr,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        pwr_down,
  output logic [3:0]               rx_cmd,
  output logic [3:0]               rx_addr,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     frame_vld,
  output logic                     frame_err,
  output logic [1:0]               dbg_state
);

  state_t state, state_nxt;

  logic                  sck_q, sck_rise, sck_fall;
  logic                  cs_q, cs_rise, cs_fall;
  logic                  mosi_q, mosi_rise, mosi_fall;
  logic [2:0]            settle_cnt;
  logic                  edges_ok;
  logic                  sck_ev, cs_r_ev, cs_f_ev;
  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  logic                  frame_ok;
  logic                  frame_bad;
  logic [3:0]            f_cmd, f_addr;
  logic [DATA_W-1:0]     f_data;
  logic [NUM_CH-1:0]     tgt;
  logic [DATA_W-1:0]     in_reg  [NUM_CH];
  logic [DATA_W-1:0]     out_reg [NUM_CH];
  logic                  unused_ok;

  sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk (clk), .rst (rst), .d (spi_sck),
    .q (sck_q), .rise (sck_rise), .fall (sck_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk (clk), .rst (rst), .d (dac_cs),
    .q (cs_q), .rise (cs_rise), .fall (cs_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .d (spi_mosi),
    .q (mosi_q), .rise (mosi_rise), .fall (mosi_fall)
  );

  // Only the synchronized mosi level and the sck/cs edges are needed
  assign unused_ok = &{1'b0, sck_q, sck_fall, cs_q, mosi_rise, mosi_fall, shreg[FRAME_BITS-1]};

  // Hold off edge detection after reset: if cs is already low at the pin,
  // the reset-to-idle sync flops would otherwise fake a falling edge and
  // start a frame in the middle of a transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      settle_cnt <= 3'd0;
    end else if (!edges_ok) begin
      settle_cnt <= settle_cnt + 3'd1;
    end
  end

  assign edges_ok = (settle_cnt == SETTLE_CYC);
  assign sck_ev   = sck_rise & edges_ok;
  assign cs_r_ev  = cs_rise & edges_ok;
  assign cs_f_ev  = cs_fall & edges_ok;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: frame opens on cs fall, closes on cs rise, decodes once
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cs_f_ev) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (cs_r_ev) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign dbg_state = state;

  // Shift register and saturating bit counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == ST_IDLE && cs_f_ev) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == ST_SHIFT && sck_ev) begin
      shreg <= {shreg[FRAME_BITS-2:0], mosi_q};
      if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
    end
  end

  assign frame_ok  = (state == ST_DECODE) && (cnt == CNT_W'(FRAME_BITS));
  assign frame_bad = (state == ST_DECODE) && (cnt != CNT_W'(FRAME_BITS));
  assign f_cmd     = shreg[CMD_MSB:CMD_LSB];
  assign f_addr    = shreg[ADDR_MSB:ADDR_LSB];
  assign f_data    = shreg[DATA_MSB:DATA_LSB];

  // Channel select: the addressed channel, or every channel on broadcast
  always_comb begin
    tgt = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      tgt[ch] = (f_addr == ADDR_ALL) || (f_addr == 4'(ch));
    end
  end

  // Status pulses and last-good-frame fields
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      rx_cmd    <= '0;
      rx_addr   <= '0;
      rx_data   <= '0;
    end else begin
      frame_vld <= frame_ok;
      frame_err <= frame_bad;
      if (frame_ok) begin
        rx_cmd  <= f_cmd;
        rx_addr <= f_addr;
        rx_data <= f_data;
      end
    end
  end

  // Channel register file; dac_clr overrides any decode in the same cycle
  always_ff @(posedge clk) begin
    if (!rst || !dac_clr) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        in_reg[ch]  <= '0;
        out_reg[ch] <= '0;
      end
      pwr_down <= '0;
    end else if (frame_ok) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        case (f_cmd)
          CMD_WR_IN: begin
            if (tgt[ch]) in_reg[ch] <= f_data;
          end
          CMD_UPD: begin
            if (tgt[ch]) begin
              out_reg[ch]  <= in_reg[ch];
              pwr_down[ch] <= 1'b0;
            end
          end
          CMD_WR_UPD_ALL: begin
            // Targets load the new code straight through; others promote input
            if (tgt[ch]) begin
              in_reg[ch]  <= f_data;
              out_reg[ch] <= f_data;
            end else begin
              out_reg[ch] <= in_reg[ch];
            end
            pwr_down[ch] <= 1'b0;
          end
          CMD_WR_UPD: begin
            if (tgt[ch]) begin
              in_reg[ch]   <= f_data;
              out_reg[ch]  <= f_data;
              pwr_down[ch] <= 1'b0;
            end
          end
          CMD_PWR_DN: begin
            if (tgt[ch]) pwr_down[ch] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Flatten output registers onto the output bus
  always_comb begin
    out_data = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      out_data[ch*DATA_W +: DATA_W] = out_reg[ch];
    end
  end

endmodule

// File: tb/tb_spi_dac_rx.sv
// Self-checking bench for spi_dac_rx. Frames are bit-banged on the SPI pins
// with sck high/low times of 4 clk; a register-level model of the DAC tracks
// what each decoded frame should do to the channel registers.
module tb_spi_dac_rx;
  import dac_defs::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     spi_sck;
  logic                     spi_mosi;
  logic                     dac_cs;
  logic                     dac_clr;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        pwr_down;
  logic [3:0]               rx_cmd;
  logic [3:0]               rx_addr;
  logic [DATA_W-1:0]        rx_data;
  logic                     frame_vld;
  logic                     frame_err;
  logic [1:0]               dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [11:0] in_m  [2];
  logic [11:0] out_m [2];
  logic [1:0]  pwr_m;
  logic [3:0]  cmd_m, addr_m;
  logic [11:0] data_m;

  spi_dac_rx dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .dac_cs    (dac_cs),
    .dac_clr   (dac_clr),
    .out_data  (out_data),
    .pwr_down  (pwr_down),
    .rx_cmd    (rx_cmd),
    .rx_addr   (rx_addr),
    .rx_data   (rx_data),
    .frame_vld (frame_vld),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      in_m[ch]  = 12'h000;
      out_m[ch] = 12'h000;
    end
    pwr_m  = 2'b00;
    cmd_m  = 4'h0;
    addr_m = 4'h0;
    data_m = 12'h000;
  endfunction

  // Effect of one good 32-bit frame; clr models dac_clr low in that cycle
  function automatic void model_frame(input logic [31:0] f, input bit clr);
    logic [3:0]  c, a;
    logic [11:0] d;
    bit          hit [2];
    c = f[23:20];
    a = f[19:16];
    d = f[15:4];
    cmd_m  = c;
    addr_m = a;
    data_m = d;
    if (clr) begin
      for (int ch = 0; ch < 2; ch++) begin
        in_m[ch]  = 12'h000;
        out_m[ch] = 12'h000;
      end
      pwr_m = 2'b00;
      return;
    end
    for (int ch = 0; ch < 2; ch++) hit[ch] = (a == 4'hF) || (int'(a) == ch);
    case (c)
      4'h0: for (int ch = 0; ch < 2; ch++) if (hit[ch]) in_m[ch] = d;
      4'h1: for (int ch = 0; ch < 2; ch++) if (hit[ch]) begin
              out_m[ch] = in_m[ch];
              pwr_m[ch] = 1'b0;
            end
      4'h2: begin
              for (int ch = 0; ch < 2; ch++) if (hit[ch]) in_m[ch] = d;
              for (int ch = 0; ch < 2; ch++) out_m[ch] = in_m[ch];
              pwr_m = 2'b00;
            end
      4'h3: for (int ch = 0; ch < 2; ch++) if (hit[ch]) begin
              in_m[ch]  = d;
              out_m[ch] = d;
              pwr_m[ch] = 1'b0;
            end
      4'h4: for (int ch = 0; ch < 2; ch++) if (hit[ch]) pwr_m[ch] = 1'b1;
      default: ;
    endcase
  endfunction

  function automatic logic [23:0] model_out();
    return {out_m[1], out_m[0]};
  endfunction

  function automatic logic [31:0] mk_frame(input logic [3:0] c, input logic [3:0] a,
                                           input logic [11:0] d);
    return {8'h00, c, a, d, 4'h0};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the low nbits of v MSB first, then raises cs and watches 12 clocks.
  // rst_at: pulse reset after that bit index (-1 = never).
  // clr_k: drive dac_clr low for the k-th clock after cs rises (0 = never).
  task automatic send_frame(input logic [39:0] v, input int nbits, input int rst_at,
                            input int clr_k, output int vld, output int err,
                            output int lat);
    dac_cs = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = v[i];
      tick(4);
      spi_sck = 1'b1;
      tick(4);
      spi_sck = 1'b0;
      if (nbits - 1 - i == rst_at) begin
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
      end
    end
    tick(4);
    vld = 0;
    err = 0;
    lat = -1;
    dac_cs = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      dac_clr = (k == clr_k) ? 1'b0 : 1'b1;
      tick(1);
      if (frame_vld === 1'b1) begin
        vld++;
        if (lat < 0) lat = k;
      end
      if (frame_err === 1'b1) begin
        err++;
        if (lat < 0) lat = k;
      end
    end
    dac_clr = 1'b1;
    tick(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int pulses;
    pulses = 0;
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      spi_sck  = ~spi_sck;
      spi_mosi = 1'($urandom_range(0, 1));
      tick(1);
      if (frame_vld !== 1'b0 || frame_err !== 1'b0) pulses++;
    end
    spi_sck = 1'b0;
    model_reset();
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %0d pulses, want 0", pulses);
    end
    n_tests++;
    if (out_data !== 24'h0 || pwr_down !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_regs: out_data=%h pwr_down=%b, want 0/00", out_data, pwr_down);
    end
    n_tests++;
    if (rx_cmd !== 4'h0 || rx_addr !== 4'h0 || rx_data !== 12'h0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_rx: cmd=%h addr=%h data=%h state=%0d, want 0 0 0 idle",
               rx_cmd, rx_addr, rx_data, dbg_state);
    end
    rst = 1'b1;
    tick(8);
  endtask

  task automatic test_single_write();
    int vld, err, lat;
    logic [31:0] f;
    f = mk_frame(4'h3, 4'h0, 12'hABC);
    send_frame({8'h00, f}, 32, -1, 0, vld, err, lat);
    model_frame(f, 1'b0);
    n_tests++;
    if (out_data[11:0] !== 12'hABC || pwr_down[0] !== 1'b0 || out_data !== model_out()) begin
      n_fail++;
      $display("FAIL single_out: out_data=%h pwr=%b, want %h pwr0=0", out_data, pwr_down, model_out());
    end
    n_tests++;
    if (vld != 1 || err != 0 || rx_cmd !== 4'h3) begin
      n_fail++;
      $display("FAIL single_vld: vld=%0d err=%0d rx_cmd=%h, want 1 0 3", vld, err, rx_cmd);
    end
    n_tests++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL single_latency: got %0d clk, want 5", lat);
    end
  endtask

  task automatic test_write_then_update();
    int vld, err, lat;
    logic [31:0] f;
    f = mk_frame(4'h0, 4'h1, 12'h123);
    send_frame({8'h00, f}, 32, -1, 0, vld, err, lat);
    model_frame(f, 1'b0);
    n_tests++;
    if (out_data[23:12] !== out_m[1] || out_data !== model_out() || vld != 1) begin
      n_fail++;
      $display("FAIL wr_input_only: out_data=%h vld=%0d, want %h 1", out_data, vld, model_out());
    end
    f = mk_frame(4'h1, 4'h1, 12'h000);
    send_frame({8'h00, f}, 32, -1, 0, vld, err, lat);
    model_frame(f, 1'b0);
    n_tests++;
    if (out_data[23:12] !== 12'h123 || out_data !== model_out() || vld != 1) begin
      n_fail++;
      $display("FAIL update_ch1: out_data=%h vld=%0d, want %h 1", out_data, vld, model_out());
    end
  endtask

  task automatic test_bad_length();
    int vld, err, lat;
    logic [31:0] f;
    f = mk_frame(4'h3, 4'h0, 12'h555);
    send_frame({8'h00, f}, 31, -1, 0, vld, err, lat);
    n_tests++;
    if (err != 1 || vld != 0 || out_data !== model_out() || rx_data !== data_m || rx_cmd !== cmd_m) begin
      n_fail++;
      $display("FAIL short_frame: err=%0d vld=%0d out=%h rx_data=%h, want 1 0 %h %h",
               err, vld, out_data, rx_data, model_out(), data_m);
    end
    send_frame({7'h00, f, 1'b1}, 33, -1, 0, vld, err, lat);
    n_tests++;
    if (err != 1 || vld != 0 || out_data !== model_out() || rx_addr !== addr_m || rx_data !== data_m) begin
      n_fail++;
      $display("FAIL long_frame: err=%0d vld=%0d out=%h rx_data=%h, want 1 0 %h %h",
               err, vld, out_data, rx_data, model_out(), data_m);
    end
  endtask

  task automatic test_pwr_down();
    int vld, err, lat;
    logic [31:0] f;
    f = mk_frame(4'h4, 4'hF, 12'h000);
    send_frame({8'h00, f}, 32, -1, 0, vld, err, lat);
    model_frame(f, 1'b0);
    n_tests++;
    if (pwr_down !== 2'b11 || out_data !== model_out()) begin
      n_fail++;
      $display("FAIL pwr_all: pwr=%b out=%h, want 11 %h", pwr_down, out_data, model_out());
    end
    f = mk_frame(4'h3, 4'h0, 12'h7FF);
    send_frame({8'h00, f}, 32, -1, 0, vld, err, lat);
    model_frame(f, 1'b0);
    n_tests++;
    if (pwr_down !== 2'b10 || out_data[11:0] !== 12'h7FF || out_data !== model_out()) begin
      n_fail++;
      $display("FAIL pwr_wake_ch0: pwr=%b out=%h, want 10 %h", pwr_down, out_data, model_out());
    end
  endtask

  task automatic test_clr_in_decode();
    int vld, err, lat;
    logic [31:0] f;
    f = mk_frame(4'h3, 4'h1, 12'h5A5);
    send_frame({8'h00, f}, 32, -1, 5, vld, err, lat);
    model_frame(f, 1'b1);
    n_tests++;
    if (out_data !== 24'h0 || pwr_down !== 2'b00 || vld != 1) begin
      n_fail++;
      $display("FAIL clr_decode: out=%h pwr=%b vld=%0d, want 0 00 1", out_data, pwr_down, vld);
    end
    n_tests++;
    if (rx_cmd !== 4'h3 || rx_addr !== 4'h1 || rx_data !== 12'h5A5) begin
      n_fail++;
      $display("FAIL clr_rx: cmd=%h addr=%h data=%h, want 3 1 5a5", rx_cmd, rx_addr, rx_data);
    end
    // Input regs were cleared too: promoting ch1 must give 0
    f = mk_frame(4'h1, 4'h1, 12'hFFF);
    send_frame({8'h00, f}, 32, -1, 0, vld, err, lat);
    model_frame(f, 1'b0);
    n_tests++;
    if (out_data !== model_out() || vld != 1) begin
      n_fail++;
      $display("FAIL clr_input: out=%h vld=%0d, want %h 1", out_data, vld, model_out());
    end
  endtask

  task automatic test_reset_mid_frame();
    int vld, err, lat;
    logic [31:0] f;
    f = mk_frame(4'h3, 4'h0, 12'h321);
    send_frame({8'h00, f}, 32, 16, 0, vld, err, lat);
    model_reset();
    n_tests++;
    if (vld != 0 || err != 0 || out_data !== 24'h0 || rx_cmd !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: vld=%0d err=%0d out=%h rx_cmd=%h, want 0 0 0 0",
               vld, err, out_data, rx_cmd);
    end
    f = mk_frame(4'h3, 4'h1, 12'h9E7);
    send_frame({8'h00, f}, 32, -1, 0, vld, err, lat);
    model_frame(f, 1'b0);
    n_tests++;
    if (vld != 1 || err != 0 || out_data !== model_out() || rx_data !== 12'h9E7) begin
      n_fail++;
      $display("FAIL rst_mid_next: vld=%0d err=%0d out=%h rx_data=%h, want 1 0 %h 9e7",
               vld, err, out_data, rx_data, model_out());
    end
  endtask

  task automatic test_random();
    int vld, err, lat;
    logic [31:0] f;
    logic [3:0]  c, a;
    logic [11:0] d;
    for (int n = 0; n < 24; n++) begin
      c = 4'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = 4'h0;
        1:       a = 4'h1;
        2:       a = 4'hF;
        default: a = 4'($urandom_range(2, 14));
      endcase
      d = 12'($urandom_range(0, 4095));
      f = {8'($urandom_range(0, 255)), c, a, d, 4'($urandom_range(0, 15))};
      send_frame({8'h00, f}, 32, -1, 0, vld, err, lat);
      model_frame(f, 1'b0);
      n_tests++;
      if (out_data !== model_out() || pwr_down !== pwr_m) begin
        n_fail++;
        $display("FAIL rand_regs[%0d]: cmd=%h addr=%h out=%h pwr=%b, want %h %b",
                 n, c, a, out_data, pwr_down, model_out(), pwr_m);
      end
      n_tests++;
      if (vld != 1 || err != 0 || rx_cmd !== cmd_m || rx_addr !== addr_m || rx_data !== data_m) begin
        n_fail++;
        $display("FAIL rand_rx[%0d]: vld=%0d err=%0d rx=%h/%h/%h, want 1 0 %h/%h/%h",
                 n, vld, err, rx_cmd, rx_addr, rx_data, cmd_m, addr_m, data_m);
      end
    end
  endtask

  initial begin
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    dac_cs   = 1'b1;
    dac_clr  = 1'b1;
    rst      = 1'b0;
    model_reset();
    tick(1);
    test_reset();
    test_single_write();
    test_write_then_update();
    test_bad_length();
    test_pwr_down();
    test_clr_in_decode();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
